// File: rtl/crc_serial_gen.sv
// crc_serial_gen -- bit-serial CRC generator.
//
// A start request captures the message and shifts it through a CRC register
// one bit per cycle, MSB first. The remainder is presented on CRC and held
// until the next start; done pulses for one cycle when it becomes valid.
//
// Optional build macro CRC_SERIAL_GEN_CHECK_EN adds an expected-CRC input
// (crc_i, captured alongside data_i) and a match flag set when the
// computation finishes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for Enable; CRC holds the last result
// ST_SHIFT | one message bit folded into the CRC register per cycle
// ST_DONE  | CRC valid, done high for this single cycle
module crc_serial_gen #(
  parameter int               DATA_W = 40,
  parameter int               CRC_W  = 7,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'('h09),
  parameter logic [CRC_W-1:0] INIT   = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Enable,
  input  logic [DATA_W-1:0] data_i,
`ifdef CRC_SERIAL_GEN_CHECK_EN
  input  logic [CRC_W-1:0]  crc_i,
  output logic              match,
`endif
  output logic [CRC_W-1:0]  CRC,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  // Count value seen while the final message bit is being processed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               start;
  logic               last_bit;

  logic [DATA_W-1:0]  msg_q;
  logic [CRC_W-1:0]   crc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               fb;
  logic [CRC_W-1:0]   crc_step;

  assign last_bit = (cnt_q == CNT_LAST);

  // One CRC step: feedback is the outgoing message bit against the CRC MSB.
  assign fb       = msg_q[DATA_W-1] ^ crc_q[CRC_W-1];
  assign crc_step = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status outputs; Enable only matters in IDLE.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          state_d = ST_SHIFT;
          start   = 1'b1;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Message/CRC/counter datapath: load on start, advance one bit per SHIFT cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      msg_q <= '0;
      crc_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      msg_q <= data_i;
      crc_q <= INIT;
      cnt_q <= '0;
    end else if (busy) begin
      msg_q <= msg_q << 1;
      crc_q <= crc_step;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign CRC = crc_q;

`ifdef CRC_SERIAL_GEN_CHECK_EN
  logic [CRC_W-1:0] crc_cap_q;
  logic             match_q;

  // Expected CRC is captured with the message; the compare uses the final
  // step value so match is already valid while done is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_cap_q <= '0;
      match_q   <= 1'b0;
    end else if (start) begin
      crc_cap_q <= crc_i;
      match_q   <= 1'b0;
    end else if (busy && last_bit) begin
      match_q   <= (crc_step == crc_cap_q);
    end
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_crc_serial_gen.sv
// Bench for crc_serial_gen: default 40/7 instance with random messages plus
// the reference vectors, a CRC-16/XMODEM instance and a single-bit instance.
// Expected remainders come from polynomial long division of the message.
module tb_crc_serial_gen;

  localparam int DW = 40;
  localparam int CW = 7;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Enable = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [CW-1:0] CRC;
  logic          busy;
  logic          done;
`ifdef CRC_SERIAL_GEN_CHECK_EN
  logic [CW-1:0] crc_i = '0;
  logic          match;
`endif

  logic          en16 = 1'b0;
  logic [71:0]   data16 = '0;
  logic [15:0]   crc16;
  logic          busy16;
  logic          done16;
`ifdef CRC_SERIAL_GEN_CHECK_EN
  logic [15:0]   crc_i16 = '0;
  logic          match16;
`endif

  logic          en1 = 1'b0;
  logic [0:0]    data1 = '0;
  logic [3:0]    crc1;
  logic          busy1;
  logic          done1;
`ifdef CRC_SERIAL_GEN_CHECK_EN
  logic [3:0]    crc_i1 = '0;
  logic          match1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  crc_serial_gen dut (
    .CLK    (CLK),
    .RST    (RST),
    .Enable (Enable),
    .data_i (data_i),
`ifdef CRC_SERIAL_GEN_CHECK_EN
    .crc_i  (crc_i),
    .match  (match),
`endif
    .CRC    (CRC),
    .busy   (busy),
    .done   (done)
  );

  crc_serial_gen #(.DATA_W(72), .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000)) dut16 (
    .CLK    (CLK),
    .RST    (RST),
    .Enable (en16),
    .data_i (data16),
`ifdef CRC_SERIAL_GEN_CHECK_EN
    .crc_i  (crc_i16),
    .match  (match16),
`endif
    .CRC    (crc16),
    .busy   (busy16),
    .done   (done16)
  );

  crc_serial_gen #(.DATA_W(1), .CRC_W(4), .POLY(4'h3), .INIT(4'h5)) dut1 (
    .CLK    (CLK),
    .RST    (RST),
    .Enable (en1),
    .data_i (data1),
`ifdef CRC_SERIAL_GEN_CHECK_EN
    .crc_i  (crc_i1),
    .match  (match1),
`endif
    .CRC    (crc1),
    .busy   (busy1),
    .done   (done1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of (msg * x^cw) / (x^cw + poly), with init folded onto the
  // leading cw bits of the dividend.
  function automatic logic [31:0] ref_crc(input logic [127:0] msg, input int dw, input int cw,
                                          input logic [31:0] poly, input logic [31:0] init);
    logic [191:0] r;
    logic [191:0] gen;
    r   = 192'(msg) << cw;
    r   = r ^ (192'(init) << dw);
    gen = (192'(1) << cw) | 192'(poly);
    for (int i = dw + cw - 1; i >= cw; i--) begin
      if (r[i]) r = r ^ (gen << (i - cw));
    end
    return 32'(r & ((192'(1) << cw) - 192'(1)));
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One computation on the default instance. lat counts edges from the
  // Enable-sampling edge to the edge that sees done high.
  task automatic run_one(input logic [DW-1:0] d, input logic rand_en,
                         output logic [CW-1:0] crc_o, output int lat,
                         output int busy_n, output logic seen);
    Enable = 1'b1;
    data_i = d;
    tick();
    Enable = 1'b0;
    data_i = DW'({$urandom(), $urandom()});
    lat    = 0;
    busy_n = 0;
    seen   = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (busy) busy_n++;
      if (rand_en) Enable = 1'($urandom_range(0, 1));
      tick();
      lat++;
      if (done) begin
        seen   = 1'b1;
        Enable = 1'b0;
      end
    end
    lat   = lat + 1;
    crc_o = CRC;
    tick();
  endtask

  initial begin : main
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [DW-1:0] d_b;
    int            lat;
    int            bn;
    int            cnt;
    logic          seen;

    RST = 1'b1;
    repeat (2) tick();
    chk("rst_crc", CRC, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    RST = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    run_one(40'h4000000000, 1'b0, c, lat, bn, seen);
    chk("v1_done_seen", seen, 1);
    chk("v1_crc", c, 7'h4A);
    chk("v1_latency", lat, 41);
    chk("v1_busy_cycles", bn, 40);
    chk("v1_done_single", done, 0);
    repeat (3) tick();
    chk("v1_crc_hold", CRC, 7'h4A);
    chk("v1_idle_busy", busy, 0);

    run_one(40'h5100000000, 1'b0, c, lat, bn, seen);
    chk("v2_crc", c, 7'h2A);
    run_one(40'h48000001AA, 1'b0, c, lat, bn, seen);
    chk("v3_crc", c, 7'h43);

    for (int i = 0; i < 20; i++) begin
      d = DW'({$urandom(), $urandom()});
      run_one(d, 1'b1, c, lat, bn, seen);
      chk("rand_crc", c, ref_crc(128'(d), DW, CW, 32'h09, 32'h0));
      chk("rand_latency", lat, 41);
      chk("rand_busy_cycles", bn, 40);
    end

    // Abort mid-run, with Enable high during reset.
    Enable = 1'b1;
    data_i = 40'h4000000000;
    tick();
    Enable = 1'b0;
    repeat (20) tick();
    chk("abort_busy_before", busy, 1);
    RST    = 1'b1;
    Enable = 1'b1;
    tick();
    chk("abort_crc", CRC, 0);
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_rst_priority", busy, 0);
    RST    = 1'b0;
    Enable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_crc_after", CRC, 0);

    RST    = 1'b1;
    Enable = 1'b1;
    tick();
    RST = 1'b0;
    run_one(40'h4000000000, 1'b0, c, lat, bn, seen);
    chk("post_rst_crc", c, 7'h4A);
    chk("post_rst_latency", lat, 41);

    // Enable held high; data changes after capture.
    d   = DW'({$urandom(), $urandom()});
    d_b = DW'({$urandom(), $urandom()});
    Enable = 1'b1;
    data_i = d;
    tick();
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (k == 10) data_i = d_b;
      tick();
      if (done) seen = 1'b1;
    end
    chk("held_done1_seen", seen, 1);
    chk("held_crc1", CRC, ref_crc(128'(d), DW, CW, 32'h09, 32'h0));
    cnt  = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      cnt++;
      if (done) seen = 1'b1;
    end
    chk("held_done2_seen", seen, 1);
    chk("held_done_spacing", cnt, 42);
    chk("held_crc2", CRC, ref_crc(128'(d_b), DW, CW, 32'h09, 32'h0));
    Enable = 1'b0;
    tick();
    tick();
    chk("held_release_idle", busy, 0);

`ifdef CRC_SERIAL_GEN_CHECK_EN
    crc_i = 7'h4A;
    run_one(40'h4000000000, 1'b0, c, lat, bn, seen);
    chk("check_match", match, 1);
    crc_i = 7'h4B;
    run_one(40'h4000000000, 1'b0, c, lat, bn, seen);
    chk("check_mismatch", match, 0);
`endif

    // CRC-16/XMODEM check string.
    en16   = 1'b1;
    data16 = "123456789";
    tick();
    en16 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      if (done16) seen = 1'b1;
    end
    chk("crc16_done_seen", seen, 1);
    chk("crc16_value", crc16, 16'h31C3);
    chk("crc16_model", crc16, ref_crc(128'("123456789"), 72, 16, 32'h1021, 32'h0));
    tick();
    chk("crc16_idle", busy16, 0);

    // Single-bit message: one SHIFT cycle, nonzero INIT.
    for (int b = 0; b < 2; b++) begin
      en1   = 1'b1;
      data1 = 1'(b);
      tick();
      en1   = 1'b0;
      data1 = ~data1;
      chk("w1_busy", busy1, 1);
      lat  = 0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        tick();
        lat++;
        if (done1) seen = 1'b1;
      end
      chk("w1_latency", lat + 1, 2);
      chk("w1_crc", crc1, ref_crc(128'(b), 1, 4, 32'h3, 32'h5));
      tick();
      chk("w1_idle", busy1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_serial_gen.md
CRC_SERIAL_GEN -- requirements
Module: crc_serial_gen

Interface
REQ-001 Parameter DATA_W, default 40, SHALL set the message width in bits.
REQ-002 Parameter CRC_W, default 7, SHALL set the CRC width in bits (legal range 4..32).
REQ-003 Parameter POLY, default 7'h09, SHALL set the generator polynomial (CRC_W bits, implicit x^CRC_W term omitted).
REQ-004 Parameter INIT, default 0, SHALL set the register value loaded at start.
REQ-005 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 RST  input  1  SHALL be the synchronous, active-high reset.
REQ-007 Enable  input  1  SHALL be the start request, sampled each cycle.
REQ-008 data_i  input  DATA_W  SHALL carry the message; processed MSB first.
REQ-009 CRC  output  CRC_W  SHALL carry the computed remainder.
REQ-010 busy  output  1  SHALL be high while bits are being shifted.
REQ-011 done  output  1  SHALL pulse high one cycle when CRC is valid.

Function
REQ-012 States SHALL be IDLE, SHIFT, DONE.
- IDLE -> SHIFT on Enable=1.
- SHIFT -> DONE after DATA_W bits.
- DONE -> IDLE unconditionally.
REQ-013 On IDLE->SHIFT, data_i SHALL be captured into an internal shift register, the CRC register loaded with INIT, and the bit counter cleared.
REQ-014 Each SHIFT cycle SHALL process one bit:
- fb = msg_msb XOR crc[CRC_W-1].
- crc = {crc[CRC_W-2:0],0} XOR (fb ? POLY : 0).
- Message register shifts left.
REQ-015 Latency SHALL be DATA_W+1 cycles from the Enable-sampling edge to the done edge.
REQ-016 busy SHALL be 1 in SHIFT only.
REQ-017 Enable while in SHIFT or DONE SHALL be ignored; data_i changes after capture SHALL NOT affect the result.
REQ-018 Enable held high continuously SHALL start a new computation on the first IDLE cycle after DONE.
REQ-019 CRC SHALL hold its value from DONE until the next IDLE->SHIFT transition.
REQ-020 CRC SHALL show the intermediate register value during SHIFT; it is only valid when done=1 or afterwards.
REQ-021 The counter SHALL be sized $clog2(DATA_W+1) bits; DATA_W=1 SHALL be legal (one SHIFT cycle).

Reset
REQ-022 RST=1 SHALL force state IDLE, CRC=0, busy=0, done=0, counter=0, and the message register to 0 on the next edge.
REQ-023 RST SHALL take priority over Enable and SHALL abort a computation in progress with no done pulse.
REQ-024 The first Enable sampled with RST=0 SHALL start a computation.

Configuration
REQ-025 Macro CRC_SERIAL_GEN_CHECK_EN, when defined, SHALL add the following.
- Input crc_i [CRC_W-1:0], captured together with data_i.
- Output match, 1 bit, reset 0, updated in DONE to (final CRC == crc_i) and held until the next start or reset.
REQ-026 Without CRC_SERIAL_GEN_CHECK_EN, crc_i and match SHALL NOT exist and the remaining behaviour SHALL be identical.

Verification
REQ-027 Default parameters, data_i=40'h4000000000, Enable pulse -> done after 41 cycles, CRC=7'h4A, busy high for exactly 40 cycles.
REQ-028 Default parameters, data_i=40'h5100000000 -> CRC=7'h2A; data_i=40'h48000001AA -> CRC=7'h43.
REQ-029 CRC_W=16, POLY=16'h1021, INIT=0, DATA_W=72, data_i=ASCII "123456789" -> CRC=16'h31C3.
REQ-030 RST asserted at bit 20 of a default run -> no done pulse, CRC=0; the next run with 40'h4000000000 -> CRC=7'h4A.
REQ-031 Enable held high and data_i changed mid-run -> first result unaffected; second done follows 42 cycles after the first.
REQ-032 With CRC_SERIAL_GEN_CHECK_EN: data_i=40'h4000000000 with crc_i=7'h4A -> match=1; with crc_i=7'h4B -> match=0.
